// File: rtl/puf_sampler.sv
// Arbiter-PUF sampling controller: captures a challenge, runs NUM_SAMPLES
// reset/launch/capture evaluations and majority-votes each response bit.
module puf_sampler #(
    parameter int CHALLENGE_WIDTH  = 64,
    parameter int PDL_CONFIG_WIDTH = 64,
    parameter int RESPONSE_WIDTH   = 6,
    parameter int NUM_SAMPLES      = 3,
    parameter int SETTLE_CYCLES    = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        trigger,
    input  logic [CHALLENGE_WIDTH-1:0]  challenge,
    input  logic [PDL_CONFIG_WIDTH-1:0] pdl_config,
    input  logic [RESPONSE_WIDTH-1:0]   puf_response,
    output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
    output logic [PDL_CONFIG_WIDTH-1:0] puf_config,
    output logic                        puf_start,
    output logic                        puf_reset,
    output logic                        busy,
    output logic                        done,
    output logic [RESPONSE_WIDTH-1:0]   raw_response,
    output logic                        xor_response,
    output logic [RESPONSE_WIDTH-1:0]   unstable
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] N_MAX       = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] N_HALF      = CNT_W'(NUM_SAMPLES / 2);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ARM, EVAL, CAPTURE, FINISH} state_t;

    state_t                      state_q, state_d;
    logic [SET_W-1:0]            settle_q, settle_d;
    logic [CNT_W-1:0]            sample_q, sample_d;
    logic [CNT_W-1:0]            ones_q [RESPONSE_WIDTH];
    logic [CNT_W-1:0]            ones_d [RESPONSE_WIDTH];
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        start_q, start_d;
    logic                        preset_q, preset_d;
    logic [RESPONSE_WIDTH-1:0]   raw_q, raw_d;
    logic [RESPONSE_WIDTH-1:0]   unstable_q, unstable_d;
    logic                        xor_q, xor_d;
    logic [CHALLENGE_WIDTH-1:0]  chal_q, chal_d;
    logic [PDL_CONFIG_WIDTH-1:0] cfg_q, cfg_d;
    logic [RESPONSE_WIDTH-1:0]   vote;
    logic [RESPONSE_WIDTH-1:0]   split;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == N_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic majority(input logic [CNT_W-1:0] ones);
        return ones > N_HALF;
    endfunction

    function automatic logic disagree(input logic [CNT_W-1:0] ones);
        return (ones != '0) && (ones != N_MAX);
    endfunction

    always_comb begin
        vote  = '0;
        split = '0;
        for (int i = 0; i < RESPONSE_WIDTH; i++) begin
            vote[i]  = majority(ones_q[i]);
            split[i] = disagree(ones_q[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        sample_d   = sample_q;
        ones_d     = ones_q;
        raw_d      = raw_q;
        unstable_d = unstable_q;
        xor_d      = xor_q;
        chal_d     = chal_q;
        cfg_d      = cfg_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    chal_d   = challenge;
                    cfg_d    = pdl_config;
                    sample_d = '0;
                    for (int i = 0; i < RESPONSE_WIDTH; i++) ones_d[i] = '0;
                    state_d  = ARM;
                end
            end
            ARM: begin
                settle_d = '0;
                state_d  = EVAL;
            end
            EVAL: begin
                if (settle_q == SETTLE_LAST) state_d = CAPTURE;
                else                         settle_d = settle_q + 1'b1;
            end
            CAPTURE: begin
                for (int i = 0; i < RESPONSE_WIDTH; i++)
                    if (puf_response[i]) ones_d[i] = sat_inc(ones_q[i]);
                sample_d = sat_inc(sample_q);
                state_d  = (sample_d < N_MAX) ? ARM : FINISH;
            end
            FINISH: begin
                raw_d      = vote;
                unstable_d = split;
                xor_d      = ^vote;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they line up with the state they describe;
        // done and the results appear the cycle after FINISH.
        start_d  = (state_d == EVAL);
        preset_d = (state_d == ARM) || (state_d == FINISH);
        busy_d   = (state_d != IDLE) || (state_q == FINISH);
        done_d   = (state_q == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            sample_q   <= '0;
            ones_q     <= '{default: '0};
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            preset_q   <= 1'b1;
            raw_q      <= '0;
            unstable_q <= '0;
            xor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            sample_q   <= sample_d;
            ones_q     <= ones_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            preset_q   <= preset_d;
            raw_q      <= raw_d;
            unstable_q <= unstable_d;
            xor_q      <= xor_d;
        end
    end

    // Captured challenge/config are pure data and carry no reset.
    always_ff @(posedge clk) begin
        chal_q <= chal_d;
        cfg_q  <= cfg_d;
    end

    assign puf_challenge = chal_q;
    assign puf_config    = cfg_q;
    assign puf_start     = start_q;
    assign puf_reset     = preset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign raw_response  = raw_q;
    assign xor_response  = xor_q;
    assign unstable      = unstable_q;

endmodule

// File: tb/tb_puf_sampler.sv
// Directed bench for puf_sampler: default build (N=3, S=4) and a minimal build (N=1, S=1).
module tb_puf_sampler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        trigger0 = 1'b0;
    logic [63:0] challenge0 = '0, pdl_config0 = '0, puf_challenge0, puf_config0;
    logic [5:0]  puf_response0 = '0, raw0, unstable0;
    logic        puf_start0, puf_reset0, busy0, done0, xor0;

    logic        trigger1 = 1'b0;
    logic [7:0]  challenge1 = '0, pdl_config1 = '0, puf_challenge1, puf_config1;
    logic [5:0]  puf_response1 = '0, raw1, unstable1;
    logic        puf_start1, puf_reset1, busy1, done1, xor1;

    always #5 clk = ~clk;

    puf_sampler #(.CHALLENGE_WIDTH(64), .PDL_CONFIG_WIDTH(64), .RESPONSE_WIDTH(6),
                  .NUM_SAMPLES(3), .SETTLE_CYCLES(4)) u0 (
        .clk(clk), .reset(reset), .trigger(trigger0), .challenge(challenge0),
        .pdl_config(pdl_config0), .puf_response(puf_response0),
        .puf_challenge(puf_challenge0), .puf_config(puf_config0),
        .puf_start(puf_start0), .puf_reset(puf_reset0), .busy(busy0), .done(done0),
        .raw_response(raw0), .xor_response(xor0), .unstable(unstable0));

    puf_sampler #(.CHALLENGE_WIDTH(8), .PDL_CONFIG_WIDTH(8), .RESPONSE_WIDTH(6),
                  .NUM_SAMPLES(1), .SETTLE_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .trigger(trigger1), .challenge(challenge1),
        .pdl_config(pdl_config1), .puf_response(puf_response1),
        .puf_challenge(puf_challenge1), .puf_config(puf_config1),
        .puf_start(puf_start1), .puf_reset(puf_reset1), .busy(busy1), .done(done1),
        .raw_response(raw1), .xor_response(xor1), .unstable(unstable1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a request on u0; on return we sit just after the accepting edge.
    task automatic launch0(input logic [63:0] chal, input logic [63:0] cfg);
        challenge0  = chal;
        pdl_config0 = cfg;
        trigger0    = 1'b1;
        tick();
        trigger0    = 1'b0;
    endtask

    // Advance until u0 done is seen or the budget runs out; c counts edges since acceptance.
    task automatic run_to_done0(inout int c);
        while (done0 !== 1'b1 && c < 80) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy0); end
        n_checks++; if (puf_start0 !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%b exp=0", puf_start0); end
        n_checks++; if (puf_reset0 !== 1'b1) begin n_fail++; $display("FAIL rst_pufreset got=%b exp=1", puf_reset0); end
        n_checks++; if ({raw0, xor0, unstable0} !== 13'd0) begin n_fail++; $display("FAIL rst_results got=%h exp=0", {raw0, xor0, unstable0}); end
        n_checks++; if (puf_reset1 !== 1'b1 || done1 !== 1'b0) begin n_fail++; $display("FAIL rst_u1 got=%b%b exp=10", puf_reset1, done1); end
        reset = 1'b0;
        tick();
        n_checks++; if (puf_reset0 !== 1'b0) begin n_fail++; $display("FAIL rst_release_pufreset got=%b exp=0", puf_reset0); end
        n_checks++; if (puf_reset1 !== 1'b0) begin n_fail++; $display("FAIL rst_release_pufreset1 got=%b exp=0", puf_reset1); end
    endtask

    task automatic test_constant_response();
        int c = 0;
        puf_response0 = 6'b101101;
        launch0(64'hA5A5_0000_1234_5678, 64'h0F0F_F0F0_0000_0001);
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL const_busy got=%b exp=1", busy0); end
        n_checks++; if (puf_reset0 !== 1'b1 || puf_start0 !== 1'b0) begin n_fail++; $display("FAIL const_arm got=%b%b exp=10", puf_reset0, puf_start0); end
        n_checks++; if (puf_challenge0 !== 64'hA5A5_0000_1234_5678) begin n_fail++; $display("FAIL const_chal got=%h exp=a5a5000012345678", puf_challenge0); end
        tick();
        c = 1;
        n_checks++; if (puf_reset0 !== 1'b0 || puf_start0 !== 1'b1) begin n_fail++; $display("FAIL const_eval got=%b%b exp=01", puf_reset0, puf_start0); end
        run_to_done0(c);
        n_checks++; if (c !== 19) begin n_fail++; $display("FAIL const_latency got=%0d exp=19", c); end
        n_checks++; if (raw0 !== 6'b101101) begin n_fail++; $display("FAIL const_raw got=%b exp=101101", raw0); end
        n_checks++; if (xor0 !== 1'b0) begin n_fail++; $display("FAIL const_xor got=%b exp=0", xor0); end
        n_checks++; if (unstable0 !== 6'b0) begin n_fail++; $display("FAIL const_unstable got=%b exp=000000", unstable0); end
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL const_busy_done got=%b exp=1", busy0); end
        n_checks++; if (puf_config0 !== 64'h0F0F_F0F0_0000_0001) begin n_fail++; $display("FAIL const_cfg got=%h exp=0f0ff0f000000001", puf_config0); end
        tick();
        n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL const_after got=%b%b exp=00", done0, busy0); end
        n_checks++; if (raw0 !== 6'b101101) begin n_fail++; $display("FAIL const_hold got=%b exp=101101", raw0); end
    endtask

    task automatic test_majority();
        int c = 0;
        puf_response0 = 6'b000001;
        launch0(64'h1, 64'h2);
        while (done0 !== 1'b1 && c < 80) begin
            if (c == 6)  puf_response0 = 6'b000011;
            if (c == 12) puf_response0 = 6'b000001;
            tick();
            c++;
        end
        n_checks++; if (c !== 19) begin n_fail++; $display("FAIL maj_latency got=%0d exp=19", c); end
        n_checks++; if (raw0 !== 6'b000001) begin n_fail++; $display("FAIL maj_raw got=%b exp=000001", raw0); end
        n_checks++; if (xor0 !== 1'b1) begin n_fail++; $display("FAIL maj_xor got=%b exp=1", xor0); end
        n_checks++; if (unstable0 !== 6'b000010) begin n_fail++; $display("FAIL maj_unstable got=%b exp=000010", unstable0); end
        tick();
    endtask

    task automatic test_trigger_while_busy();
        int c = 0;
        int extra = 0;
        launch0(64'hCAFE_F00D_0000_00AA, 64'h55);
        while (done0 !== 1'b1 && c < 80) begin
            challenge0  = 64'hDEAD_0000_0000_0000 | 64'(c);
            pdl_config0 = 64'(c);
            trigger0    = 1'b1;
            n_checks++; if (puf_challenge0 !== 64'hCAFE_F00D_0000_00AA) begin n_fail++; $display("FAIL busy_chal c=%0d got=%h exp=cafef00d000000aa", c, puf_challenge0); end
            tick();
            c++;
        end
        trigger0 = 1'b0;
        n_checks++; if (c !== 19) begin n_fail++; $display("FAIL busy_latency got=%0d exp=19", c); end
        n_checks++; if (puf_config0 !== 64'h55) begin n_fail++; $display("FAIL busy_cfg got=%h exp=55", puf_config0); end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done0 === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_extra_done got=%0d exp=0", extra); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL busy_idle got=%b exp=0", busy0); end
        launch0(64'h0123_4567_89AB_CDEF, 64'h77);
        n_checks++; if (puf_challenge0 !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL busy_newchal got=%h exp=0123456789abcdef", puf_challenge0); end
        c = 0;
        run_to_done0(c);
        n_checks++; if (c !== 19) begin n_fail++; $display("FAIL busy_second_latency got=%0d exp=19", c); end
        tick();
    endtask

    task automatic test_reset_mid_eval();
        int c = 0;
        int dones = 0;
        launch0(64'h99, 64'h98);
        while (c < 9) begin
            tick();
            c++;
        end
        n_checks++; if (puf_start0 !== 1'b1) begin n_fail++; $display("FAIL abort_in_eval got=%b exp=1", puf_start0); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({done0, busy0, puf_start0, puf_reset0} !== 4'b0001) begin n_fail++; $display("FAIL abort_ctrl got=%b exp=0001", {done0, busy0, puf_start0, puf_reset0}); end
        n_checks++; if ({raw0, xor0, unstable0} !== 13'd0) begin n_fail++; $display("FAIL abort_results got=%h exp=0", {raw0, xor0, unstable0}); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done0 === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        n_checks++; if (puf_reset0 !== 1'b0) begin n_fail++; $display("FAIL abort_pufreset got=%b exp=0", puf_reset0); end
        puf_response0 = 6'b111000;
        launch0(64'h42, 64'h43);
        c = 0;
        run_to_done0(c);
        n_checks++; if (c !== 19) begin n_fail++; $display("FAIL abort_rerun_latency got=%0d exp=19", c); end
        n_checks++; if (raw0 !== 6'b111000 || xor0 !== 1'b1) begin n_fail++; $display("FAIL abort_rerun_raw got=%b/%b exp=111000/1", raw0, xor0); end
        tick();
    endtask

    task automatic test_back_to_back();
        int c = 0;
        puf_response0 = 6'b010101;
        launch0(64'h1111, 64'h1);
        while (c < 18) begin
            tick();
            c++;
        end
        n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_finish got=%b%b exp=01", done0, busy0); end
        challenge0 = 64'h2222;
        trigger0   = 1'b1;
        tick();
        c++;
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got=%b exp=1", done0); end
        n_checks++; if (puf_challenge0 !== 64'h1111) begin n_fail++; $display("FAIL b2b_finish_ignored got=%h exp=1111", puf_challenge0); end
        challenge0 = 64'h3333;
        tick();
        c++;
        trigger0 = 1'b0;
        n_checks++; if (puf_challenge0 !== 64'h3333) begin n_fail++; $display("FAIL b2b_accept got=%h exp=3333", puf_challenge0); end
        n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got=%b%b exp=01", done0, busy0); end
        run_to_done0(c);
        n_checks++; if (c !== 39) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=39", c); end
        n_checks++; if (raw0 !== 6'b010101 || xor0 !== 1'b1) begin n_fail++; $display("FAIL b2b_raw got=%b/%b exp=010101/1", raw0, xor0); end
        tick();
    endtask

    task automatic test_single_sample();
        int c = 0;
        int starts = 0;
        puf_response1 = 6'b110100;
        challenge1    = 8'h3C;
        pdl_config1   = 8'hC3;
        trigger1      = 1'b1;
        tick();
        trigger1      = 1'b0;
        while (done1 !== 1'b1 && c < 20) begin
            if (puf_start1 === 1'b1) starts++;
            tick();
            c++;
        end
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL n1_latency got=%0d exp=4", c); end
        n_checks++; if (starts !== 1) begin n_fail++; $display("FAIL n1_start_cycles got=%0d exp=1", starts); end
        n_checks++; if (raw1 !== 6'b110100) begin n_fail++; $display("FAIL n1_raw got=%b exp=110100", raw1); end
        n_checks++; if (xor1 !== 1'b1 || unstable1 !== 6'b0) begin n_fail++; $display("FAIL n1_xor_unstable got=%b/%b exp=1/000000", xor1, unstable1); end
        n_checks++; if (puf_challenge1 !== 8'h3C || puf_config1 !== 8'hC3) begin n_fail++; $display("FAIL n1_capture got=%h/%h exp=3c/c3", puf_challenge1, puf_config1); end
        tick();
    endtask

    initial begin
        test_reset();
        test_constant_response();
        test_majority();
        test_trigger_while_busy();
        test_reset_mid_eval();
        test_back_to_back();
        test_single_sample();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/puf_sampler.md
PUF_SAMPLER -- requirements
Module: puf_sampler

Interface
REQ-001 Parameter CHALLENGE_WIDTH, default 64: challenge bits driven to the PUF core.
REQ-002 Parameter PDL_CONFIG_WIDTH, default 64: PDL delay-config bits driven to the PUF core.
REQ-003 Parameter RESPONSE_WIDTH, default 6: raw response bits per evaluation.
REQ-004 Parameter NUM_SAMPLES, default 3: evaluations per request; odd, 1..31.
REQ-005 Parameter SETTLE_CYCLES, default 15: cycles puf_start is held per evaluation; 1..255.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 trigger  input  1  request pulse; sampled only in IDLE.
REQ-009 challenge  input  CHALLENGE_WIDTH  challenge, captured on accepted trigger.
REQ-010 pdl_config  input  PDL_CONFIG_WIDTH  PDL config, captured on accepted trigger.
REQ-011 puf_response  input  RESPONSE_WIDTH  arbiter outputs from the PUF core.
REQ-012 puf_challenge  output  CHALLENGE_WIDTH  registered copy of captured challenge.
REQ-013 puf_config  output  PDL_CONFIG_WIDTH  registered copy of captured pdl_config.
REQ-014 puf_start  output  1  launches race edge into the PUF core.
REQ-015 puf_reset  output  1  clears PUF core arbiters.
REQ-016 busy  output  1  high from accepted trigger until done pulse inclusive.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 raw_response  output  RESPONSE_WIDTH  per-bit majority vote over NUM_SAMPLES evaluations.
REQ-019 xor_response  output  1  XOR reduction of raw_response.
REQ-020 unstable  output  RESPONSE_WIDTH  per bit: 1 if samples disagreed (0 < ones count < NUM_SAMPLES).

Function
REQ-021 FSM states SHALL be IDLE, ARM, EVAL, CAPTURE, FINISH.
REQ-022 IDLE: trigger=1 SHALL capture challenge/pdl_config, clear all ones counters and sample counter, go ARM; trigger=0 stays IDLE.
REQ-023 Trigger while busy SHALL be ignored, with no effect on captured inputs or counters.
REQ-024 ARM (1 cycle): puf_reset=1, puf_start=0, settle counter cleared, go EVAL.
REQ-025 EVAL: puf_reset=0, puf_start=1 for exactly SETTLE_CYCLES consecutive cycles, then CAPTURE.
REQ-026 CAPTURE (1 cycle): puf_start=0; each ones counter SHALL increment where puf_response bit is 1; sample counter increments.
REQ-027 CAPTURE SHALL go ARM if fewer than NUM_SAMPLES samples are taken, else FINISH.
REQ-028 FINISH (1 cycle): register raw_response[i] = (ones[i] > NUM_SAMPLES/2), unstable, xor_response; done=1; puf_reset=1; go IDLE.
REQ-029 Ones counters SHALL be $clog2(NUM_SAMPLES+1) bits wide and SHALL never wrap.
REQ-030 done SHALL assert exactly NUM_SAMPLES*(SETTLE_CYCLES+2)+1 cycles after the trigger-accepting edge.
REQ-031 raw_response, xor_response, unstable SHALL hold their values until the next FINISH.
REQ-032 A trigger present in the FINISH cycle SHALL be ignored; a trigger in the following cycle (IDLE) SHALL be accepted.
REQ-033 puf_challenge/puf_config SHALL remain stable from capture until the next accepted trigger.

Reset
REQ-034 When reset=1 at an edge: state=IDLE, done=0, busy=0, puf_start=0, puf_reset=1, raw_response=0, xor_response=0, unstable=0, all counters 0.
REQ-035 Reset SHALL take priority over every state, including mid-EVAL; no done pulse SHALL follow an aborted request.
REQ-036 In IDLE after reset, puf_reset SHALL drop to 0 on the first non-reset cycle.

Verification
REQ-037 N=3, S=4, puf_response constant 6'b101101, trigger -> done 19 cycles later, raw=101101, xor=0, unstable=0.
REQ-038 N=3, samples 6'b000001, 6'b000011, 6'b000001 -> raw=000001, xor=1, unstable=000010.
REQ-039 Trigger pulsed every cycle during a request with new challenge -> single done, puf_challenge unchanged until next IDLE trigger.
REQ-040 Reset asserted in 3rd EVAL cycle of sample 2 -> outputs at reset values next cycle, no done; new trigger gives full-latency run.
REQ-041 N=1, S=1 -> done 4 cycles after trigger; puf_start high exactly 1 cycle; raw equals sampled puf_response.
REQ-042 Back-to-back: trigger in FINISH cycle ignored, trigger next cycle accepted -> second done after full latency.
